ccd_frame_source: RTL
=====================

Name: ccd_frame_source

Overview:
- Synthesizable sensor-side source for the camera capture path: produces the 10-bit pixel data, LVAL and FVAL that the camera header normally drives into CCD_Capture.
- Allows the capture, RAW2RGB, Detection and SDRAM/VGA chain to run in simulation and on the board without a camera.
- Sits in front of the GPIO-sampled camera registers, with a switch-selected mux.
- Emits fixed, predictable patterns so downstream pixel counts and values can be checked exactly.

Parameters:
- H_ACTIVE, 1280, active pixels per line (1..2047)
- V_ACTIVE, 1024, active lines per frame (1..2047)
- H_BLANK, 16, LVAL-low cycles between lines (>=1)
- V_BLANK, 64, FVAL-low cycles between frames (>=1)
- SOF_CYC, 4, cycles with FVAL high before the first line (>=1)
- EOF_CYC, 4, cycles with FVAL high after the last line (>=1)

Ports:
- iCLK  input  1  pixel clock; the only clock
- iRST  input  1  synchronous, active-high reset
- iCE  input  1  pixel enable; when 0 all state and outputs hold
- iSTART  input  1  level; sets the run latch
- iSTOP  input  1  level; clears the run latch
- iPATTERN  input  2  pattern select, latched at SOF entry
- oDATA  output  10  pixel value
- oLVAL  output  1  line valid
- oFVAL  output  1  frame valid
- oX_Cont  output  11  column of the current oDATA
- oY_Cont  output  11  row of the current oDATA
- oFrame_Cont  output  32  completed-frame count
- oCRC  output  16  frame CRC (optional feature)
- oCRC_VALID  output  1  one-cycle CRC strobe (optional feature)

Behaviour:
- All outputs are registered. Reset values: oDATA=0, oLVAL=0, oFVAL=0, oX_Cont=0, oY_Cont=0, oFrame_Cont=0, oCRC=0, oCRC_VALID=0. After reset: state IDLE, run latch clear, pattern latch 0.
- Every state transition and counter step below occurs only on cycles with iCE=1.
- Run latch: set by iSTART, cleared by iSTOP. If both are high in the same cycle, iSTOP wins.
- FSM states and transitions:
  - IDLE: FVAL=0, LVAL=0. Go to SOF on the cycle after the run latch is set.
  - SOF: FVAL=1, LVAL=0 for SOF_CYC cycles. On entry, latch iPATTERN and clear y. Then go to LINE.
  - LINE: FVAL=1, LVAL=1 for H_ACTIVE cycles; x steps 0..H_ACTIVE-1. oDATA, oX_Cont and oY_Cont are valid in the same cycle as LVAL. After the last pixel: if y=V_ACTIVE-1 go to EOF, else go to HBLANK.
  - HBLANK: FVAL=1, LVAL=0 for H_BLANK cycles; increment y on the first cycle. Then go to LINE.
  - EOF: FVAL=1, LVAL=0 for EOF_CYC cycles. On exit, increment oFrame_Cont (wraps at 2^32).
  - VBLANK: FVAL=0 for V_BLANK cycles. Then go to SOF if the run latch is set, else IDLE.
- Stop semantics: iSTOP mid-frame does not truncate the frame; the current frame always completes through VBLANK.
- oDATA outside LINE is 0; oX_Cont and oY_Cont hold their last values.
- Patterns (x, y are the 11-bit active coordinates):
  - 0: horizontal ramp, x[9:0]
  - 1: vertical ramp, y[9:0]
  - 2: checker, 10'h3FF if x[4]^y[4], else 0
  - 3: Bayer ID by {y[0], x[0]}: 00 -> 10'h200 (G1), 01 -> 10'h3FF (R), 10 -> 10'h100 (B), 11 -> 10'h080 (G2)
- iPATTERN changes mid-frame have no effect until the next SOF.
- iCE low: freezes everything, including the blanking counters; there is no timeout.
- Reset mid-frame: outputs take reset values on the next edge.
- Frame period = SOF_CYC + V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK + EOF_CYC + V_BLANK enabled cycles.

Optional Feature:
- Macro: CCD_FRAME_SOURCE_CRC_EN.
- When defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first) is computed over each active pixel's 10 bits zero-extended to 16 bits, in emission order.
  - On the last EOF cycle, oCRC is loaded with the final value and oCRC_VALID pulses for 1 cycle.
  - oCRC holds until the next frame's strobe.
  - The accumulator resets to 0xFFFF at SOF entry.
- When not defined: oCRC=0 and oCRC_VALID=0 constantly, and no CRC logic is built.

Test Plan:
- Bench parameters: H_ACTIVE=8, V_ACTIVE=4, H_BLANK=3, V_BLANK=5, SOF_CYC=2, EOF_CYC=2; iCE=1 unless stated.
- Reset, then iSTART pulse with iPATTERN=0 -> FVAL rises 1 cycle later; FVAL high 45 cycles; 4 LVAL bursts of 8 with data 0..7 each; 3-cycle gaps; oFrame_Cont=1 after EOF; next FVAL rise 50 cycles after the first.
- iPATTERN=3 -> row 0 data 200,3FF,200,3FF...; row 1 data 100,080,100,080... (hex).
- iSTOP asserted during row 2 -> frame completes with all 32 pixels; FVAL low from then on; state IDLE; oFrame_Cont incremented once.
- iSTART and iSTOP high together while IDLE -> no frame starts.
- iCE toggled 1/0 every cycle -> identical pixel sequence to the continuous run, at half rate.
- iRST asserted mid-LINE -> next edge FVAL=0, LVAL=0, oFrame_Cont=0; no frame starts until a new iSTART.
- With CCD_FRAME_SOURCE_CRC_EN and pattern 2 -> oCRC_VALID pulses once per frame; oCRC equals the bench model's value for 32 zero pixels; the value repeats identically on the following frame.

Source files
------------

// File: rtl/ccd_frame_source.sv
// Synthetic CCD sensor source: 10-bit pixels with LVAL/FVAL timing and fixed test patterns.
// Optional frame CRC-16-CCITT on oCRC/oCRC_VALID when CCD_FRAME_SOURCE_CRC_EN is defined.
module ccd_frame_source #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned V_ACTIVE = 1024,
    parameter int unsigned H_BLANK  = 16,
    parameter int unsigned V_BLANK  = 64,
    parameter int unsigned SOF_CYC  = 4,
    parameter int unsigned EOF_CYC  = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iCE,
    input  logic        iSTART,
    input  logic        iSTOP,
    input  logic [1:0]  iPATTERN,
    output logic [9:0]  oDATA,
    output logic        oLVAL,
    output logic        oFVAL,
    output logic [10:0] oX_Cont,
    output logic [10:0] oY_Cont,
    output logic [31:0] oFrame_Cont,
    output logic [15:0] oCRC,
    output logic        oCRC_VALID
);

    localparam int unsigned MAX_AB   = (H_ACTIVE > H_BLANK) ? H_ACTIVE : H_BLANK;
    localparam int unsigned MAX_CD   = (V_BLANK > SOF_CYC) ? V_BLANK : SOF_CYC;
    localparam int unsigned MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned MAX_CYC  = (MAX_ABCD > EOF_CYC) ? MAX_ABCD : EOF_CYC;
    localparam int unsigned CNT_W    = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SOF_LAST  = CNT_W'(SOF_CYC - 1);
    localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HBL_LAST  = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] EOF_LAST  = CNT_W'(EOF_CYC - 1);
    localparam logic [CNT_W-1:0] VBL_LAST  = CNT_W'(V_BLANK - 1);
    localparam logic [10:0]      Y_LAST    = 11'(V_ACTIVE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SOF, S_LINE, S_HBLANK, S_EOF, S_VBLANK
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic [1:0]       pat_q, pat_d;
    logic [10:0]      y_q, y_d;
    logic [9:0]       data_q, data_d;
    logic             lval_q, lval_d;
    logic             fval_q, fval_d;
    logic [10:0]      xo_q, xo_d;
    logic [10:0]      yo_q, yo_d;
    logic [31:0]      frame_q, frame_d;
    logic             start_frame;
    logic             emit;
    logic [10:0]      emit_x;
    logic [9:0]       emit_data;

    function automatic logic [9:0] pixel_f(input logic [1:0] pat,
                                           input logic [9:0] x,
                                           input logic [9:0] y);
        logic [9:0] p;
        case (pat)
            2'd0:    p = x;
            2'd1:    p = y;
            2'd2:    p = (x[4] ^ y[4]) ? 10'h3FF : 10'h000;
            default: begin
                case ({y[0], x[0]})
                    2'b00:   p = 10'h200;
                    2'b01:   p = 10'h3FF;
                    2'b10:   p = 10'h100;
                    default: p = 10'h080;
                endcase
            end
        endcase
        return p;
    endfunction

`ifdef CCD_FRAME_SOURCE_CRC_EN
    logic [15:0] acc_q, acc_d;
    logic [15:0] crc_q, crc_d;
    logic        crc_vld_q, crc_vld_d;

    // CRC-16-CCITT, MSB first, over one zero-extended pixel
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [9:0] pix);
        logic [15:0] c;
        logic [15:0] d;
        c = crc;
        d = {6'd0, pix};
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction
`endif

    assign emit_data = pixel_f(pat_q, emit_x[9:0], y_q[9:0]);

    // Next-state and next-output logic; everything holds while iCE is low
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        run_d       = run_q;
        pat_d       = pat_q;
        y_d         = y_q;
        data_d      = data_q;
        lval_d      = lval_q;
        fval_d      = fval_q;
        xo_d        = xo_q;
        yo_d        = yo_q;
        frame_d     = frame_q;
        start_frame = 1'b0;
        emit        = 1'b0;
        emit_x      = '0;
`ifdef CCD_FRAME_SOURCE_CRC_EN
        acc_d       = acc_q;
        crc_d       = crc_q;
        crc_vld_d   = crc_vld_q;
`endif
        if (iCE) begin
            run_d  = iSTOP ? 1'b0 : (iSTART ? 1'b1 : run_q);
            lval_d = 1'b0;
            data_d = '0;
            cnt_d  = cnt_q + CNT_W'(1);
`ifdef CCD_FRAME_SOURCE_CRC_EN
            crc_vld_d = 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (run_q) start_frame = 1'b1;
                end
                S_SOF: begin
                    if (cnt_q == SOF_LAST) begin
                        state_d = S_LINE;
                        cnt_d   = '0;
                        emit    = 1'b1;
                    end
                end
                S_LINE: begin
                    if (cnt_q == LINE_LAST) begin
                        cnt_d = '0;
                        if (y_q == Y_LAST) begin
                            state_d = S_EOF;
                        end else begin
                            state_d = S_HBLANK;
                            y_d     = y_q + 11'd1;
                        end
                    end else begin
                        emit   = 1'b1;
                        emit_x = 11'(cnt_q) + 11'd1;
                    end
                end
                S_HBLANK: begin
                    if (cnt_q == HBL_LAST) begin
                        state_d = S_LINE;
                        cnt_d   = '0;
                        emit    = 1'b1;
                    end
                end
                S_EOF: begin
                    if (cnt_q == EOF_LAST) begin
                        state_d = S_VBLANK;
                        cnt_d   = '0;
                        fval_d  = 1'b0;
                        frame_d = frame_q + 32'd1;
`ifdef CCD_FRAME_SOURCE_CRC_EN
                        crc_d     = acc_q;
                        crc_vld_d = 1'b1;
`endif
                    end
                end
                S_VBLANK: begin
                    if (cnt_q == VBL_LAST) begin
                        cnt_d = '0;
                        if (run_q) start_frame = 1'b1;
                        else       state_d     = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    fval_d  = 1'b0;
                end
            endcase
            if (start_frame) begin
                state_d = S_SOF;
                cnt_d   = '0;
                fval_d  = 1'b1;
                pat_d   = iPATTERN;
                y_d     = '0;
`ifdef CCD_FRAME_SOURCE_CRC_EN
                acc_d   = 16'hFFFF;
`endif
            end
            if (emit) begin
                lval_d = 1'b1;
                data_d = emit_data;
                xo_d   = emit_x;
                yo_d   = y_q;
`ifdef CCD_FRAME_SOURCE_CRC_EN
                acc_d  = crc_step(acc_q, emit_data);
`endif
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            pat_q   <= '0;
            y_q     <= '0;
            data_q  <= '0;
            lval_q  <= 1'b0;
            fval_q  <= 1'b0;
            xo_q    <= '0;
            yo_q    <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            pat_q   <= pat_d;
            y_q     <= y_d;
            data_q  <= data_d;
            lval_q  <= lval_d;
            fval_q  <= fval_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            frame_q <= frame_d;
        end
    end

`ifdef CCD_FRAME_SOURCE_CRC_EN
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            acc_q     <= 16'hFFFF;
            crc_q     <= '0;
            crc_vld_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            crc_q     <= crc_d;
            crc_vld_q <= crc_vld_d;
        end
    end

    assign oCRC       = crc_q;
    assign oCRC_VALID = crc_vld_q;
`else
    assign oCRC       = '0;
    assign oCRC_VALID = 1'b0;
`endif

    assign oDATA       = data_q;
    assign oLVAL       = lval_q;
    assign oFVAL       = fval_q;
    assign oX_Cont     = xo_q;
    assign oY_Cont     = yo_q;
    assign oFrame_Cont = frame_q;

endmodule
